// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage.
//   INSTR_NOP     : word shown on instr while nothing has been fetched (addi x0,x0,0)
//   fetch_state_e : fetch FSM state codes (2-bit)
//   fetch_entry_t : one queue entry, the PC and instruction word fetched from it
package ifetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Instruction queue: DEPTH-entry synchronous FIFO of {pc, instr}.
//   clk, rst     : clock, asynchronous active-high reset
//   push_i       : write push_data_i at the tail
//   push_data_i  : entry to store
//   pop_i        : drop the head entry
//   flush_i      : empty the queue; wins over push and pop in the same cycle
//   head_o       : head entry, straight from registered storage
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
module ifetch_queue
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      // NOTE: storage is reset so the head reads NOP at RESET_PC before
      // anything has been fetched; downstream still gates on instr_valid.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{pc: RESET_PC, instr: INSTR_NOP};
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage feeding decode.
//   clk, rst        : clock, asynchronous active-high reset
//   imem_req/addr   : word fetch request toward instruction memory (addr[1:0] = 0)
//   imem_gnt        : request accepted this cycle
//   imem_rvalid/rdata: read response, one per accepted request
//   redirect_valid/pc: one-cycle redirect from branch/jump resolution
//   instr_valid/ready: handshake toward decode
//   instr, instr_pc : head instruction and its PC
//   fetch_misalign  : one-cycle pulse after a redirect whose target had addr[1:0] != 0
// At most one request is outstanding. Each request is tagged with a 1-bit epoch;
// a redirect toggles the epoch so the response to a request issued before it is dropped.
module ifetch_unit
  import ifetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         epoch_q, epoch_d;
  logic         pend_epoch_q, pend_epoch_d;
  logic         misalign_q;

  logic         q_push;
  logic         q_full;
  logic         q_empty;
  fetch_entry_t q_head;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    epoch_d      = epoch_q;
    pend_epoch_d = pend_epoch_q;
    q_push       = 1'b0;
    imem_req     = (state_q == S_REQ) && !q_full;

    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        // A grant in the redirect cycle still counts as issued; it carries the
        // old epoch, so its response is discarded later.
        if (imem_req && imem_gnt) begin
          pend_epoch_d = epoch_q;
          pend_pc_d    = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + 32'd4;
          state_d      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          q_push  = (pend_epoch_q == epoch_q) && !redirect_valid;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      epoch_d    = ~epoch_q;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fetch_pc_q   <= RESET_PC;
      pend_pc_q    <= RESET_PC;
      epoch_q      <= 1'b0;
      pend_epoch_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      epoch_q      <= epoch_d;
      pend_epoch_q <= pend_epoch_d;
      misalign_q   <= redirect_valid && (redirect_pc[1:0] != 2'b00);
    end
  end

  ifetch_queue #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (q_push),
    .push_data_i ('{pc: pend_pc_q, instr: imem_rdata}),
    .pop_i       (instr_valid && instr_ready),
    .flush_i     (redirect_valid),
    .head_o      (q_head),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  assign imem_addr      = fetch_pc_q;
  assign instr_valid    = !q_empty;
  assign instr          = q_head.instr;
  assign instr_pc       = q_head.pc;
  assign fetch_misalign = misalign_q;

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;
  import ifetch_unit_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_misalign;

  always #5 clk = ~clk;

  ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .fetch_misalign (fetch_misalign)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model: words decode should see, in order, and the fetch address stream.
  logic [31:0] mq[$];
  logic [31:0] exp_addr;
  logic [31:0] pend_addr;
  bit          outstanding;
  bit          stale;
  int          lat_left;
  bit          after_reset;
  bit          exp_misalign;

  // Stimulus knobs: 0 = drive low, 1 = drive high, 2 = random.
  int          gnt_mode;
  int          ready_mode;
  int          lat_fix;
  bit          redir_go;
  logic [31:0] redir_tgt;
  bit          junk_rv;
  int          issue_cnt;
  bit          found;

  task automatic tick();
    bit deliver;
    bit issue;
    bit pop;
    @(negedge clk);
    check("instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("instr_pc", instr_pc, mq[0]);
      check("instr", instr, mem_word(mq[0]));
    end
    check("imem_req", 32'(imem_req), 32'(!outstanding && (mq.size() < DEPTH) && !after_reset));
    if (imem_req) check("imem_addr", imem_addr, exp_addr);
    check("fetch_misalign", 32'(fetch_misalign), 32'(exp_misalign));

    deliver = 1'b0;
    if (outstanding) begin
      lat_left--;
      deliver = (lat_left == 0);
    end
    imem_rvalid = deliver || junk_rv;
    imem_rdata  = deliver ? mem_word(pend_addr) : $urandom();
    case (gnt_mode)
      0:       imem_gnt = 1'b0;
      1:       imem_gnt = 1'b1;
      default: imem_gnt = 1'($urandom_range(0, 1));
    endcase
    case (ready_mode)
      0:       instr_ready = 1'b0;
      1:       instr_ready = 1'b1;
      default: instr_ready = 1'($urandom_range(0, 1));
    endcase
    redirect_valid = redir_go;
    redirect_pc    = redir_go ? redir_tgt : $urandom();

    issue = imem_req && imem_gnt;
    pop   = (mq.size() > 0) && instr_ready;
    if (pop && !redir_go) void'(mq.pop_front());
    if (deliver) begin
      outstanding = 1'b0;
      if (!stale && !redir_go) mq.push_back(pend_addr);
    end
    if (redir_go) begin
      mq.delete();
      stale = 1'b1;
    end
    if (issue) begin
      outstanding = 1'b1;
      stale       = redir_go;
      pend_addr   = exp_addr;
      lat_left    = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 3));
      exp_addr    = exp_addr + 32'd4;
      issue_cnt++;
    end
    if (redir_go) exp_addr = {redir_tgt[31:2], 2'b00};
    exp_misalign = redir_go && (redir_tgt[1:0] != 2'b00);
    after_reset  = 1'b0;
    redir_go     = 1'b0;
    junk_rv      = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    exp_addr     = RESET_PC;
    outstanding  = 1'b0;
    stale        = 1'b0;
    after_reset  = 1'b1;
    exp_misalign = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    gnt_mode       = 0;
    ready_mode     = 0;
    lat_fix        = 1;
    redir_go       = 1'b0;
    redir_tgt      = '0;
    junk_rv        = 1'b0;
    issue_cnt      = 0;
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr, INSTR_NOP);
    check("rst_instr_pc", instr_pc, RESET_PC);
    check("rst_misalign", 32'(fetch_misalign), 32'd0);
    rst = 1'b0;

    // Streaming: grant always, response one cycle later, decode always ready.
    gnt_mode = 1; ready_mode = 1; lat_fix = 1;
    repeat (12) tick();

    // Decode stalled: exactly DEPTH requests, then one more per pop.
    gnt_mode = 0;
    repeat (4) tick();
    ready_mode = 0; gnt_mode = 1; issue_cnt = 0;
    repeat (10) tick();
    check("stall_issue_cnt", 32'(issue_cnt), 32'(DEPTH));
    check("stall_req_low", 32'(imem_req), 32'd0);
    ready_mode = 1;
    tick();
    ready_mode = 0; issue_cnt = 0;
    repeat (6) tick();
    check("one_pop_one_issue", 32'(issue_cnt), 32'd1);

    // Redirect while a response is outstanding.
    ready_mode = 1; gnt_mode = 0;
    repeat (4) tick();
    lat_fix = 3; gnt_mode = 1;
    tick();
    redir_go = 1'b1; redir_tgt = 32'h0000_0100;
    tick();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin found = 1'b1; break; end
      tick();
    end
    check("wait_redir_valid", 32'(found), 32'd1);
    check("redir_first_pc", instr_pc, 32'h0000_0100);

    // Redirect in the same cycle the request for address 8 is granted.
    lat_fix = 1; gnt_mode = 0;
    redir_go = 1'b1; redir_tgt = 32'h0000_0000;
    repeat (4) tick();
    gnt_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_addr == 32'h0000_0008) begin found = 1'b1; break; end
      tick();
    end
    check("wait_addr8", 32'(found), 32'd1);
    redir_go = 1'b1; redir_tgt = 32'h0000_0340;
    tick();
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin found = 1'b1; break; end
      tick();
    end
    check("wait_req_after_gnt_redir", 32'(found), 32'd1);
    check("gnt_redir_next_addr", imem_addr, 32'h0000_0340);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin found = 1'b1; break; end
      tick();
    end
    check("wait_gnt_redir_valid", 32'(found), 32'd1);
    check("gnt_redir_first_pc", instr_pc, 32'h0000_0340);

    // Misaligned redirect target, then address wrap at the top of memory.
    gnt_mode = 0;
    repeat (4) tick();
    redir_go = 1'b1; redir_tgt = 32'h0000_0203;
    tick();
    check("misalign_pulse", 32'(fetch_misalign), 32'd1);
    check("misalign_addr", imem_addr, 32'h0000_0200);
    tick();
    check("misalign_one_cycle", 32'(fetch_misalign), 32'd0);
    redir_go = 1'b1; redir_tgt = 32'hFFFF_FFFC;
    tick();
    gnt_mode = 1;
    tick();
    tick();
    check("wrap_req", 32'(imem_req), 32'd1);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    repeat (4) tick();

    // Reset while a response is outstanding and the queue holds data.
    ready_mode = 0; lat_fix = 3; gnt_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() >= 1 && outstanding) begin found = 1'b1; break; end
      tick();
    end
    check("wait_reset_setup", 32'(found), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_req", 32'(imem_req), 32'd0);
    imem_gnt = 1'b0; imem_rvalid = 1'b0; redirect_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    check("rst_held_valid", 32'(instr_valid), 32'd0);
    model_reset();
    rst = 1'b0;
    junk_rv = 1'b1; gnt_mode = 1; ready_mode = 1; lat_fix = 0;
    repeat (12) tick();

    // Random traffic with occasional redirects.
    gnt_mode = 2; ready_mode = 2; lat_fix = 0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        redir_go  = 1'b1;
        redir_tgt = $urandom();
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
